// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle ARM control unit.
// Holds the FSM state enum, ALUControl codes, datapath mux select constants,
// data-processing command / multiply subtype codes and small decode helpers.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_MULEX  = 4'd9,
        S_MULWB  = 4'd10,
        S_BRANCH = 4'd11
    } state_t;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_UMULL = 3'b101;
    localparam logic [2:0] ALU_SMULL = 3'b110;

    // Datapath mux selects
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;
    localparam logic [1:0] SRCA_REG      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] IMM_DP        = 2'b00;
    localparam logic [1:0] IMM_MEM       = 2'b01;
    localparam logic [1:0] IMM_BR        = 2'b10;

    // Instruction classes (Instr[27:26])
    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_UND = 2'b11;

    // Data-processing commands (Instr[24:21])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Multiply subtypes (Instr[23:21])
    localparam logic [2:0] MULT_MUL   = 3'b000;
    localparam logic [2:0] MULT_UMULL = 3'b100;
    localparam logic [2:0] MULT_SMULL = 3'b110;

    // Unrecognised DP commands fall back to AND.
    function automatic logic [2:0] dp_alu(input logic [3:0] cmd);
        logic [2:0] code;
        case (cmd)
            CMD_ADD:          code = ALU_ADD;
            CMD_SUB, CMD_CMP: code = ALU_SUB;
            CMD_ORR:          code = ALU_ORR;
            default:          code = ALU_AND;
        endcase
        return code;
    endfunction

    // Unrecognised multiply subtypes fall back to the 32-bit MUL.
    function automatic logic [2:0] mul_alu(input logic [2:0] sub);
        logic [2:0] code;
        case (sub)
            MULT_UMULL: code = ALU_UMULL;
            MULT_SMULL: code = ALU_SMULL;
            default:    code = ALU_MUL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// mc_if: instruction/flag inputs and every datapath control strobe of the
// multicycle core. 'slave' is the control unit's view, 'master' the datapath's.
interface mc_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        RegWrite2;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;

    modport slave (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, RegWrite2, IRWrite, AdrSrc,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );

    modport master (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, RegWrite2, IRWrite, AdrSrc,
               RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl
    );
endinterface

// File: rtl/mc_control_cond_check.sv
// cond_check: ARM condition-code evaluation.
//   cond  in 4 : Instr[31:28]
//   flags in 4 : stored flags {N,Z,C,V}
//   cond_ex out 1 : condition passes (1111 is treated as never)
module cond_check (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n_s, z_s, c_s, v_s;
    assign {n_s, z_s, c_s, v_s} = flags;

    // Condition lookup
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_s;
            4'b0001: cond_ex = ~z_s;
            4'b0010: cond_ex = c_s;
            4'b0011: cond_ex = ~c_s;
            4'b0100: cond_ex = n_s;
            4'b0101: cond_ex = ~n_s;
            4'b0110: cond_ex = v_s;
            4'b0111: cond_ex = ~v_s;
            4'b1000: cond_ex = c_s & ~z_s;
            4'b1001: cond_ex = ~c_s | z_s;
            4'b1010: cond_ex = (n_s == v_s);
            4'b1011: cond_ex = (n_s != v_s);
            4'b1100: cond_ex = ~z_s & (n_s == v_s);
            4'b1101: cond_ex = z_s | (n_s != v_s);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle control unit (main FSM, DP/multiply decode, flags).
//   clk, reset : core clock, synchronous active-high reset
//   bus (slave): Instr/ALUFlags in; PCWrite, MemWrite, RegWrite, RegWrite2,
//                IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
//                ALUControl out (combinational decode of state and Instr).
module mc_control
    import mc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mc_if.slave  bus
);
    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [1:0] op_cls;
    logic [3:0] cmd;
    logic [2:0] mul_sub;
    logic       is_mul, is_ldr, is_cmp, is_long, rd_is_pc, cond_ex;
    logic       unused_instr_bits;

    assign op_cls   = bus.Instr[27:26];
    assign cmd      = bus.Instr[24:21];
    assign mul_sub  = bus.Instr[23:21];
    assign is_mul   = (op_cls == CLS_DP) && !bus.Instr[25] && (bus.Instr[7:4] == 4'b1001);
    assign is_ldr   = bus.Instr[20];
    assign is_cmp   = (cmd == CMD_CMP);
    assign is_long  = (mul_sub == MULT_UMULL) || (mul_sub == MULT_SMULL);
    assign rd_is_pc = (bus.Instr[15:12] == 4'd15);
    // Register numbers are consumed by the datapath, not here.
    assign unused_instr_bits = ^{bus.Instr[19:16], bus.Instr[11:8], bus.Instr[3:0]};

    cond_check u_cond_check (
        .cond    (bus.Instr[31:28]),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // State and flags registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_cls)
                    CLS_MEM: state_d = S_MEMADR;
                    CLS_BR:  state_d = S_BRANCH;
                    CLS_DP: begin
                        if (is_mul) begin
                            state_d = S_MULEX;
                        end else if (bus.Instr[25]) begin
                            state_d = S_EXECI;
                        end else begin
                            state_d = S_EXECR;
                        end
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = is_ldr ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_MULEX:  state_d = S_MULWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Flags update at the end of a DP execute step; C/V only move for arithmetic
    always_comb begin
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ex && (bus.Instr[20] || is_cmp)) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP) begin
                flags_d[1:0] = bus.ALUFlags[1:0];
            end else begin
                flags_d[1:0] = flags_q[1:0];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // Per-state control decode, condition gating, then reset override
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.RegWrite2  = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = ADR_PC;
        bus.RegSrc     = 2'b00;
        bus.ALUSrcA    = SRCA_REG;
        bus.ALUSrcB    = SRCB_REG;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ImmSrc     = IMM_DP;
        bus.ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
                // STR reads its data register through RA2; branches read R15 through RA1.
                if (op_cls == CLS_MEM && !is_ldr) begin
                    bus.RegSrc = 2'b10;
                end else if (op_cls == CLS_BR) begin
                    bus.RegSrc = 2'b01;
                end else begin
                    bus.RegSrc = 2'b00;
                end
            end
            S_MEMADR: begin
                bus.ALUSrcB    = SRCB_IMM;
                bus.ImmSrc     = IMM_MEM;
                bus.ALUControl = bus.Instr[23] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: begin
                bus.AdrSrc    = ADR_RESULT;
                bus.ResultSrc = RES_ALUOUT;
            end
            S_MEMWR: begin
                bus.AdrSrc    = ADR_RESULT;
                bus.ResultSrc = RES_ALUOUT;
                bus.MemWrite  = cond_ex;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = cond_ex;
                bus.PCWrite   = cond_ex && rd_is_pc;
            end
            S_EXECR: begin
                bus.ALUSrcB    = SRCB_REG;
                bus.ALUControl = dp_alu(cmd);
            end
            S_EXECI: begin
                bus.ALUSrcB    = SRCB_IMM;
                bus.ImmSrc     = IMM_DP;
                bus.ALUControl = dp_alu(cmd);
            end
            S_ALUWB: begin
                bus.ResultSrc = RES_ALUOUT;
                bus.RegWrite  = cond_ex && !is_cmp;
                bus.PCWrite   = cond_ex && !is_cmp && rd_is_pc;
            end
            S_MULEX: begin
                bus.ALUControl = mul_alu(mul_sub);
            end
            S_MULWB: begin
                bus.ALUControl = mul_alu(mul_sub);
                bus.ResultSrc  = RES_ALURESULT;
                bus.RegWrite   = cond_ex;
                bus.RegWrite2  = cond_ex && is_long;
            end
            S_BRANCH: begin
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ImmSrc    = IMM_BR;
                bus.ResultSrc = RES_ALURESULT;
                bus.PCWrite   = cond_ex;
            end
            default: begin
                bus.ALUControl = ALU_ADD;
            end
        endcase
        // Reset silences every write and parks the muxes on their FETCH values.
        if (reset) begin
            bus.PCWrite    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.RegWrite2  = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.AdrSrc     = ADR_PC;
            bus.RegSrc     = 2'b00;
            bus.ALUSrcA    = SRCA_PC;
            bus.ALUSrcB    = SRCB_FOUR;
            bus.ResultSrc  = RES_ALURESULT;
            bus.ImmSrc     = IMM_DP;
            bus.ALUControl = ALU_ADD;
        end else begin
            bus.IRWrite = bus.IRWrite;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench for mc_control. A reference model derives, per
// instruction, the list of steps and the control word expected in each step;
// a negedge monitor pops and compares one control word per cycle.
module tb_mc_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_if bus ();
    mc_control dut (.clk(clk), .reset(reset), .bus(bus));

    localparam int T_F = 0, T_D = 1, T_MA = 2, T_MR = 3, T_MWB = 4, T_MW = 5;
    localparam int T_ER = 6, T_EI = 7, T_AW = 8, T_MX = 9, T_MLW = 10, T_B = 11;

    typedef struct {
        logic [18:0] v;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          seq[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  m_flags;
    exp_t        mon_e;
    logic [18:0] mon_act;

    function automatic logic [18:0] pk(input logic pcw, memw, regw, regw2, irw, adr,
                                       input logic [1:0] rs, sa, sb, res, imm,
                                       input logic [2:0] alu);
        return {pcw, memw, regw, regw2, irw, adr, rs, sa, sb, res, imm, alu};
    endfunction

    function automatic string nm(input int s);
        string names[12] = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB", "MEMWR",
                             "EXECR", "EXECI", "ALUWB", "MULEX", "MULWB", "BRANCH"};
        return names[s];
    endfunction

    // ARM condition rules over {N,Z,C,V}
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'h0: return z;          4'h1: return !z;
            4'h2: return c;          4'h3: return !c;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return c && !z;    4'h9: return !c || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Step list of one instruction
    task automatic fill_seq(input logic [31:0] i);
        seq = '{T_F, T_D};
        case (i[27:26])
            2'b01: begin
                seq.push_back(T_MA);
                if (i[20]) begin seq.push_back(T_MR); seq.push_back(T_MWB); end
                else seq.push_back(T_MW);
            end
            2'b00: begin
                if (!i[25] && i[7:4] == 4'b1001) begin seq.push_back(T_MX); seq.push_back(T_MLW); end
                else begin seq.push_back(i[25] ? T_EI : T_ER); seq.push_back(T_AW); end
            end
            2'b10: seq.push_back(T_B);
            default: ;
        endcase
    endtask

    task automatic push_exp(input logic [18:0] v, input string tag);
        exp_t e;
        e.v = v;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Expected control word for step s, then the flag-register effect of that step
    task automatic model_cycle(input int s, input logic [31:0] i, input logic [3:0] afl);
        logic pcw, memw, regw, regw2, irw, adr, c, cmp, lng;
        logic [1:0] rs, sa, sb, res, imm;
        logic [2:0] alu, dpc, mulc;
        logic [3:0] cmd;
        pcw = 0; memw = 0; regw = 0; regw2 = 0; irw = 0; adr = 0;
        rs = 0; sa = 0; sb = 0; res = 0; imm = 0; alu = 0;
        c = cond_ok(i[31:28], m_flags);
        cmd = i[24:21];
        cmp = (cmd == 4'b1010);
        if (cmd == 4'b0100) dpc = 3'd0;
        else if (cmd == 4'b0010 || cmp) dpc = 3'd1;
        else if (cmd == 4'b1100) dpc = 3'd3;
        else dpc = 3'd2;
        lng = (i[23:21] == 3'b100) || (i[23:21] == 3'b110);
        mulc = (i[23:21] == 3'b100) ? 3'd5 : (i[23:21] == 3'b110) ? 3'd6 : 3'd4;
        case (s)
            T_F:   begin irw = 1; pcw = 1; sa = 1; sb = 2; res = 2; end
            T_D:   begin sa = 1; sb = 2; res = 2;
                         rs = (i[27:26] == 2'b01 && !i[20]) ? 2'b10 : (i[27:26] == 2'b10) ? 2'b01 : 2'b00; end
            T_MA:  begin sb = 1; imm = 1; alu = i[23] ? 3'd0 : 3'd1; end
            T_MR:  begin adr = 1; end
            T_MW:  begin adr = 1; memw = c; end
            T_MWB: begin res = 1; regw = c; pcw = c && i[15:12] == 4'd15; end
            T_ER:  begin alu = dpc; end
            T_EI:  begin sb = 1; alu = dpc; end
            T_AW:  begin regw = c && !cmp; pcw = regw && i[15:12] == 4'd15; end
            T_MX:  begin alu = mulc; end
            T_MLW: begin alu = mulc; res = 2; regw = c; regw2 = c && lng; end
            default: begin sa = 1; sb = 1; imm = 2; res = 2; pcw = c; end
        endcase
        push_exp(pk(pcw, memw, regw, regw2, irw, adr, rs, sa, sb, res, imm, alu),
                 $sformatf("%s@%08h", nm(s), i));
        if ((s == T_ER || s == T_EI) && c && (i[20] || cmp)) begin
            m_flags[3:2] = afl[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010 || cmp) m_flags[1:0] = afl[1:0];
        end
    endtask

    task automatic reset_cycle(input string tag);
        reset = 1'b1;
        push_exp(pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000), tag);
        m_flags = 4'b0000;
        @(posedge clk); #1;
    endtask

    // Runs one instruction; abort_at >= 0 asserts reset in that step instead
    task automatic run_instr(input logic [31:0] i, input int abort_at,
                             input logic fl_fix, input logic [3:0] fl_val);
        logic [3:0] afl;
        fill_seq(i);
        for (int k = 0; k < seq.size(); k++) begin
            if (k == abort_at) begin
                reset_cycle($sformatf("reset_abort@%08h", i));
                reset = 1'b0;
                return;
            end
            reset = 1'b0;
            bus.Instr = i;
            afl = fl_fix ? fl_val : 4'($urandom);
            bus.ALUFlags = afl;
            model_cycle(seq[k], i, afl);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [3:0] cmds[5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
        logic [2:0] subs[3] = '{3'b000, 3'b100, 3'b110};
        i = $urandom;
        if ($urandom_range(0, 1) == 0) i[31:28] = 4'hE;
        if ($urandom_range(0, 2) == 0) i[24:21] = cmds[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) begin
            i[27:25] = 3'b000;
            i[7:4] = 4'b1001;
            if ($urandom_range(0, 3) != 0) i[23:21] = subs[$urandom_range(0, 2)];
        end
        if ($urandom_range(0, 3) == 0) i[15:12] = 4'd15;
        return i;
    endfunction

    // Monitor: one control word per cycle, compared against the scoreboard head
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_act = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.RegWrite2, bus.IRWrite,
                       bus.AdrSrc, bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                       bus.ImmSrc, bus.ALUControl};
            checks++;
            if (mon_act !== mon_e.v) begin
                errors++;
                $display("FAIL %s got %b expected %b (pcw,memw,rw,rw2,irw,adr,rs,sa,sb,res,imm,alu)",
                         mon_e.tag, mon_act, mon_e.v);
            end
        end
    end

    initial begin
        int ab;
        logic [31:0] ri;
        reset = 1'b1;
        bus.Instr = 32'h0;
        bus.ALUFlags = 4'h0;
        m_flags = 4'h0;
        @(posedge clk); #1;
        reset_cycle("reset_init0");
        reset_cycle("reset_init1");
        reset = 1'b0;

        run_instr(32'hE0821003, -1, 1'b1, 4'b0000);   // ADD R1,R2,R3
        run_instr(32'hE5904008, -1, 1'b0, 4'b0000);   // LDR R4,[R0,#8]
        run_instr(32'hE2511001, -1, 1'b1, 4'b0100);   // SUBS -> Z=1
        run_instr(32'h0A000002, -1, 1'b0, 4'b0000);   // BEQ taken
        run_instr(32'hE2511001, -1, 1'b1, 4'b0000);   // SUBS -> Z=0
        run_instr(32'h0A000002, -1, 1'b0, 4'b0000);   // BEQ not taken
        run_instr(32'hE0812394, -1, 1'b0, 4'b0000);   // UMULL
        run_instr(32'hE1500001, -1, 1'b1, 4'b0000);   // CMP R0,R1 -> Z=0
        run_instr(32'h05804008, -1, 1'b0, 4'b0000);   // STREQ suppressed
        run_instr(32'hE5904008, 3, 1'b0, 4'b0000);    // LDR aborted in MEMRD
        run_instr(32'hE0821003, -1, 1'b0, 4'b0000);

        for (int n = 0; n < 400; n++) begin
            ri = rand_instr();
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ri, ab, 1'b0, 4'b0000);
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
